// File: rtl/sisc_pkg.sv
// Shared SISC datapath definitions: bus width defaults, responder state encoding
// and the wait-state limit.
package sisc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 16;
    localparam int WAIT_MAX   = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_t;

endpackage

// File: rtl/dm_resp_if.sv
// Data-memory access bus between the SISC controller (master) and dm_resp (slave).
interface dm_resp_if
    import sisc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, busy
    );

endinterface

// File: rtl/dm_array.sv
// DEPTH x DATA_W data-memory storage: synchronous write port, registered read port.
module dm_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata    <= mem[idx];
    end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: accepts one request, waits WAIT_STATES cycles, then acks.
// Optional access counters (rd_cnt/wr_cnt) are built when DM_ACCESS_CNT_EN is defined.
module dm_resp
    import sisc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_f,
    dm_resp_if.slave    bus
`ifdef DM_ACCESS_CNT_EN
    ,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
`endif
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_bad_wait
        $error("dm_resp: WAIT_STATES must be within 0..15");
    end

    dm_state_t         state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_in_range, in_range_q;
    logic              enter_resp, arr_we, arr_re;
    logic [DATA_W-1:0] arr_rdata;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == ST_IDLE && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    cnt_nx   = WAIT_LD;
                    state_nx = (WAIT_LD != 4'd0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = ST_RESP;
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // With zero wait states the array is accessed on the acceptance edge itself,
    // before the request registers hold anything, so take the live bus then.
    assign acc_we       = (state == ST_IDLE) ? bus.we    : we_q;
    assign acc_addr     = (state == ST_IDLE) ? bus.addr  : addr_q;
    assign acc_wdata    = (state == ST_IDLE) ? bus.wdata : wdata_q;
    assign acc_in_range = {1'b0, acc_addr} < (ADDR_W+1)'(DEPTH);
    assign in_range_q   = {1'b0, addr_q}   < (ADDR_W+1)'(DEPTH);

    // rst_f gate keeps an access from landing while reset is held with req high.
    assign enter_resp = rst_f && (state_nx == ST_RESP) && (state != ST_RESP);
    assign arr_we     = enter_resp &&  acc_we && acc_in_range;
    assign arr_re     = enter_resp && !acc_we && acc_in_range;

    dm_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (acc_addr[IDX_W-1:0]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    assign bus.ack   = (state == ST_RESP);
    assign bus.busy  = (state != ST_IDLE);
    assign bus.err   = bus.ack && !in_range_q;
    assign bus.rdata = (bus.ack && in_range_q && !we_q) ? arr_rdata : '0;

`ifdef DM_ACCESS_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (bus.ack && !bus.err) begin
            if (we_q) wr_cnt <= sat_inc(wr_cnt);
            else      rd_cnt <= sat_inc(rd_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_dm_resp.sv
// Directed scoreboard bench for dm_resp: one instance with 2 wait states, one with 0.
module tb_dm_resp;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } sb_t;

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    sb_t  sb_a[$];
    sb_t  sb_b[$];
    logic prev_ack_a = 1'b0;
    logic prev_ack_b = 1'b0;
    logic [31:0] data_b [3] = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC};

    always #5 clk = ~clk;

    dm_resp_if #(.DATA_W(32), .ADDR_W(16)) ifa ();
    dm_resp_if #(.DATA_W(32), .ADDR_W(16)) ifb ();

`ifdef DM_ACCESS_CNT_EN
    logic [15:0] rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b;
`endif

    dm_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(2)) dut_a (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (ifa)
`ifdef DM_ACCESS_CNT_EN
        ,
        .rd_cnt (rd_cnt_a),
        .wr_cnt (wr_cnt_a)
`endif
    );

    dm_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) dut_b (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (ifb)
`ifdef DM_ACCESS_CNT_EN
        ,
        .rd_cnt (rd_cnt_b),
        .wr_cnt (wr_cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the 2-wait-state instance; inputs are scrambled once accepted.
    task automatic acc_a(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
        sb_a.push_back('{exp_rd, exp_err, chk_rd});
        ifa.req = 1'b1; ifa.we = w; ifa.addr = a; ifa.wdata = d;
        @(posedge clk); #1;
        ifa.req = 1'b0; ifa.we = ~w; ifa.addr = ~a; ifa.wdata = ~d;
        for (int c = 1; c <= 3; c++) begin
            check("busy_a", 32'(ifa.busy), 32'd1);
            check("ack_timing_a", 32'(ifa.ack), 32'(c == 3));
            if (c < 3) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        check("busy_done_a", 32'(ifa.busy), 32'd0);
        check("ack_done_a", 32'(ifa.ack), 32'd0);
    endtask

    always @(negedge clk) begin : mon_a
        sb_t e;
        if (rst_f) begin
            if (ifa.ack) begin
                if (sb_a.size() == 0) check("spurious_ack_a", 32'(sb_a.size()), 32'd1);
                else begin
                    e = sb_a.pop_front();
                    check("err_a", 32'(ifa.err), 32'(e.err));
                    if (e.chk) check("rdata_a", ifa.rdata, e.rdata);
                end
            end else if (prev_ack_a) begin
                check("rdata_after_ack_a", ifa.rdata, 32'd0);
                check("err_after_ack_a", 32'(ifa.err), 32'd0);
            end
        end
        prev_ack_a <= ifa.ack;
    end

    always @(negedge clk) begin : mon_b
        sb_t e;
        if (rst_f) begin
            if (ifb.ack) begin
                if (sb_b.size() == 0) check("spurious_ack_b", 32'(sb_b.size()), 32'd1);
                else begin
                    e = sb_b.pop_front();
                    check("err_b", 32'(ifb.err), 32'(e.err));
                    if (e.chk) check("rdata_b", ifb.rdata, e.rdata);
                end
            end else if (prev_ack_b) begin
                check("rdata_after_ack_b", ifb.rdata, 32'd0);
            end
        end
        prev_ack_b <= ifb.ack;
    end

    initial begin
        ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0;
        ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0;
        #12;
        check("rst_ack_a", 32'(ifa.ack), 32'd0);
        check("rst_busy_a", 32'(ifa.busy), 32'd0);
        check("rst_err_a", 32'(ifa.err), 32'd0);
        check("rst_rdata_a", ifa.rdata, 32'd0);
        check("rst_busy_b", 32'(ifb.busy), 32'd0);
        @(posedge clk); #1;
        rst_f = 1'b1;
        @(posedge clk); #1;

        acc_a(1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        acc_a(1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
        acc_a(1'b1, 16'h0000, 32'h12345678, 32'h0, 1'b0, 1'b0);
        acc_a(1'b1, 16'h0100, 32'hFFFF0000, 32'h0, 1'b1, 1'b0);
        acc_a(1'b0, 16'h0000, 32'h0,        32'h12345678, 1'b0, 1'b1);
        acc_a(1'b0, 16'hFFFF, 32'h0,        32'h0, 1'b1, 1'b1);
        acc_a(1'b1, 16'h0020, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
`ifdef DM_ACCESS_CNT_EN
        check("wr_cnt_a", 32'(wr_cnt_a), 32'd3);
        check("rd_cnt_a", 32'(rd_cnt_a), 32'd2);
`endif

        // Back-to-back on the zero-wait instance with req held high.
        ifb.req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ifb.we = (i < 3); ifb.addr = 16'(16'h0040 + (i % 3)); ifb.wdata = data_b[i % 3];
            sb_b.push_back('{data_b[i % 3], 1'b0, (i >= 3)});
            @(posedge clk); #1;
            check("ack_b_on", 32'(ifb.ack), 32'd1);
            @(posedge clk); #1;
            check("ack_b_off", 32'(ifb.ack), 32'd0);
            if (i == 5) ifb.req = 1'b0;
        end

        // Abort a write to 0x20 with an asynchronous reset while in WAIT.
        ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 16'h0020; ifa.wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        ifa.req = 1'b0;
        check("busy_before_abort", 32'(ifa.busy), 32'd1);
        #2 rst_f = 1'b0;
        #1;
        check("busy_async_rst", 32'(ifa.busy), 32'd0);
        check("ack_async_rst", 32'(ifa.ack), 32'd0);
        @(posedge clk); #1;
        rst_f = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("ack_after_abort", 32'(ifa.ack), 32'd0);
        end
`ifdef DM_ACCESS_CNT_EN
        check("wr_cnt_a_rst", 32'(wr_cnt_a), 32'd0);
`endif
        acc_a(1'b0, 16'h0020, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
`ifdef DM_ACCESS_CNT_EN
        check("rd_cnt_a_post", 32'(rd_cnt_a), 32'd1);
`endif

        repeat (3) @(posedge clk);
        check("sb_a_drained", 32'(sb_a.size()), 32'd0);
        check("sb_b_drained", 32'(sb_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
